sram_controller: RTL and testbench

Bridges the ARM pipeline's MEM stage to the external 16-bit SRAM. Each 32-bit word load/store becomes two halfword SRAM accesses. While an access is in flight the block holds `ready` low, and the pipeline freezes on that. It sits directly upstream of the SRAM model and drives every `SRAM_*` pin of the processor top.

---
 rtl/sram_controller_pkg.sv | 22 ++
 rtl/sram_phase_counter.sv | 41 ++++
 rtl/sram_controller.sv | 181 ++++++++++++++++++
 tb/tb_sram_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and address helper for the MEM-stage SRAM bridge.
package sram_controller_pkg;

    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;
    localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    // Word index relative to the SRAM base; out-of-range indices wrap silently.
    function automatic logic [WORD_IDX_LEN-1:0] word_index(input logic [31:0] addr,
                                                           input logic [31:0] base);
        return WORD_IDX_LEN'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Hold counter that stretches each halfword phase by WAIT_CYCLES extra cycles.
// Only instantiated when SRAM_WAIT_EN is defined.
module sram_phase_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == CW'(WAIT_CYCLES));

    // Restart on load, otherwise count up and saturate at the expiry value.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses, holding ready low meanwhile.
// Define SRAM_WAIT_EN to stretch every halfword phase by WAIT_CYCLES extra cycles.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = DATA_MEM_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [31:0]               address,
    input  logic [31:0]               write_data,
    output logic [31:0]               read_data,
    output logic                      ready,
    inout  wire  [SRAM_DATA_LEN-1:0]  SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0]  SRAM_ADDR,
    output logic                      SRAM_UB_N,
    output logic                      SRAM_LB_N,
    output logic                      SRAM_WE_N,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_OE_N
);

    sram_state_e               state_q, state_d;
    logic                      op_write_q, op_write_d;
    logic [WORD_IDX_LEN-1:0]   word_q, word_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;

    logic                      req_s;
    logic                      phase_expired_s;
    logic                      cnt_load_s;
    logic                      cnt_en_s;
    logic                      dq_oe_s;
    logic [SRAM_DATA_LEN-1:0]  dq_out_s;
    logic [SRAM_ADDR_LEN-1:0]  sram_addr_s;
    logic                      we_n_s;

    assign req_s = wr_en | rd_en;

`ifdef SRAM_WAIT_EN
    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (cnt_load_s),
        .enable_i  (cnt_en_s),
        .expired_o (phase_expired_s)
    );
`else
    logic unused_cfg_s;

    assign phase_expired_s = 1'b1;
    assign unused_cfg_s    = ^{cnt_load_s, cnt_en_s, 32'(WAIT_CYCLES)};
`endif

    // Next-state logic: latch the request on IDLE->LO, capture read halves as each phase ends.
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d    = LO;
                    op_write_d = wr_en;
                    word_d     = word_index(address, BASE_ADDR);
                    wdata_d    = write_data;
                    cnt_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                cnt_en_s = 1'b1;
                if (phase_expired_s) begin
                    state_d    = HI;
                    cnt_load_s = 1'b1;
                    if (!op_write_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = LO;
                end
            end
            HI: begin
                cnt_en_s = 1'b1;
                if (phase_expired_s) begin
                    state_d = DONE;
                    if (!op_write_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = HI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and access-context registers; reset abandons any partial transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            word_q     <= {WORD_IDX_LEN{1'b0}};
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // SRAM pin decode, derived only from registered state so the strobe cannot glitch on inputs.
    always_comb begin
        sram_addr_s = {SRAM_ADDR_LEN{1'b0}};
        we_n_s      = 1'b1;
        dq_oe_s     = 1'b0;
        dq_out_s    = {SRAM_DATA_LEN{1'b0}};
        case (state_q)
            LO: begin
                sram_addr_s = {word_q, 1'b0};
                if (op_write_q) begin
                    we_n_s   = 1'b0;
                    dq_oe_s  = 1'b1;
                    dq_out_s = wdata_q[15:0];
                end else begin
                    we_n_s  = 1'b1;
                    dq_oe_s = 1'b0;
                end
            end
            HI: begin
                sram_addr_s = {word_q, 1'b1};
                if (op_write_q) begin
                    we_n_s   = 1'b0;
                    dq_oe_s  = 1'b1;
                    dq_out_s = wdata_q[31:16];
                end else begin
                    we_n_s  = 1'b1;
                    dq_oe_s = 1'b0;
                end
            end
            default: begin
                sram_addr_s = {SRAM_ADDR_LEN{1'b0}};
                we_n_s      = 1'b1;
            end
        endcase
    end

    assign SRAM_DQ   = dq_oe_s ? dq_out_s : {SRAM_DATA_LEN{1'bz}};
    assign SRAM_ADDR = sram_addr_s;
    assign SRAM_WE_N = we_n_s;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign read_data = rdata_q;
    assign ready     = (state_q == DONE) | ((state_q == IDLE) & ~req_s);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;

    localparam int unsigned WAIT = 1;
`ifdef SRAM_WAIT_EN
    localparam int LAT = 3 + 2 * WAIT;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    logic [15:0] mem [0:63];
    logic        mem_clr;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          lo_idx;
        logic [15:0] lo_val;
        logic [15:0] hi_val;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    // SRAM model: asynchronous read, write on the clock edge while WE_N is low.
    assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[5:0]] <= SRAM_DQ;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_write(input int id, input int lo_idx, input logic [31:0] d);
        exp_t e;
        e.is_read = 1'b0; e.rdata = 32'd0; e.lo_idx = lo_idx;
        e.lo_val = d[15:0]; e.hi_val = d[31:16]; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic push_read(input int id, input logic [31:0] d);
        exp_t e;
        e.is_read = 1'b1; e.rdata = d; e.lo_idx = 0;
        e.lo_val = 16'h0000; e.hi_val = 16'h0000; e.id = id;
        exp_q.push_back(e);
    endtask

    // Drive one request and hold it until n completions are seen (bounded).
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input int n);
        int got;
        got = 0;
        @(posedge clk); #1;
        wr_en = w; rd_en = r; address = a; write_data = d;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            if (ready) got++;
        end
        if (got < n) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d completions expected %0d", got, n);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Monitor: measures latency and pops/compares the scoreboard at each completion.
    initial begin : monitor
        int   cyc;
        logic we_bad;
        exp_t e;
        cyc = 0;
        we_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (wr_en || rd_en)) begin
                if (exp_q.size() > 0 && exp_q[0].is_read && SRAM_WE_N !== 1'b1) we_bad = 1'b1;
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("latency_acc%0d", e.id), 32'(cyc), 32'(LAT));
                        if (e.is_read) begin
                            check($sformatf("rdata_acc%0d", e.id), read_data, e.rdata);
                            check($sformatf("we_n_high_acc%0d", e.id), 32'(we_bad), 32'd0);
                        end else begin
                            check($sformatf("mem_lo_acc%0d", e.id), 32'(mem[e.lo_idx]), 32'(e.lo_val));
                            check($sformatf("mem_hi_acc%0d", e.id), 32'(mem[e.lo_idx + 1]), 32'(e.hi_val));
                        end
                    end
                    cyc = 0;
                    we_bad = 1'b0;
                end else begin
                    cyc++;
                end
            end else begin
                cyc = 0;
                we_bad = 1'b0;
            end
        end
    end

    initial begin : stimulus
        bit found;
        rst = 1'b1; mem_clr = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 mem_clr = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_we_n", 32'(SRAM_WE_N), 32'd1);
        check("reset_read_data", read_data, 32'd0);
        check("reset_sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("tieoffs", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        push_write(1, 2, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1);
        push_read(2, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1);
        push_write(3, 0, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'd1024, 32'h0BADF00D, 1);
        push_write(4, 4, 32'h12345678);
        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1);
        // Index 2^17 + 8 wraps to word 8 (halfwords 16/17).
        push_write(5, 16, 32'hA1B2C3D4);
        access(1'b1, 1'b0, 32'd525344, 32'hA1B2C3D4, 1);
        push_read(6, 32'hA1B2C3D4);
        access(1'b0, 1'b1, 32'd1056, 32'h0, 1);

        // Back-to-back reads with rd_en held; address changes only between accesses.
        push_read(7, 32'h0BADF00D);
        push_read(8, 32'hDEADBEEF);
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'd1024;
        begin : b2b
            int got;
            got = 0;
            for (int k = 0; k < 200 && got < 2; k++) begin
                @(negedge clk);
                if (ready) begin
                    got++;
                    if (got == 1) begin
                        @(posedge clk); #1 address = 32'd1028;
                    end
                end
            end
            if (got < 2) begin
                checks++; errors++;
                $display("FAIL timeout_b2b: got %0d completions expected 2", got);
            end
        end
        @(posedge clk); #1 rd_en = 1'b0;

        // Reset during the high-half phase of a write to 1036.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFE1234;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (SRAM_ADDR == 18'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_hi_phase", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        check("rst_ready_req_held", 32'(ready), 32'd0);
        wr_en = 1'b0;
        #1;
        check("rst_ready_no_req", 32'(ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem6_lo_written", 32'(mem[6]), 32'h00001234);
        check("rst_mem7_untouched", 32'(mem[7]), 32'h00000000);

        push_read(9, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1);

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
